// File: rtl/piso_serializer_tx_if.sv
// Load and serial-link signals of the PISO transmitter.
// The master side is the transmitter itself; the slave side is its environment.
interface piso_serializer_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_last;
  logic             busy;
  logic             done;

  modport master (
    input  load_data, load_valid, ser_ready,
    output load_ready, ser_out, ser_valid, ser_last, busy, done
  );

  modport slave (
    output load_data, load_valid, ser_ready,
    input  load_ready, ser_out, ser_valid, ser_last, busy, done
  );
endinterface

// File: rtl/piso_serializer_tx.sv
// Parallel-in/serial-out transmitter: takes one word on the load handshake and
// sends it a bit per accepted serial beat, pulsing done after the final bit.
module piso_serializer_tx #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic                   clk,
  input logic                   reset,
  piso_serializer_tx_if.master  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    count;
  logic             done_q;

  // Every output is decoded from registered state, so load_valid and
  // ser_ready never reach an output combinationally.
  assign bus.load_ready = (state == IDLE);
  assign bus.busy       = (state == SHIFT);
  assign bus.ser_valid  = (state == SHIFT);
  assign bus.ser_last   = (state == SHIFT) && (count == LAST_IDX);
  assign bus.ser_out    = (state == SHIFT) &&
                          (LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1]);
  assign bus.done       = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      count     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            shift_reg <= bus.load_data;
            count     <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.ser_ready) begin
            if (count == LAST_IDX) begin
              shift_reg <= '0;
              count     <= '0;
              done_q    <= 1'b1;
              state     <= IDLE;
            end else begin
              // Move the next bit toward the output end, zero-filling behind it.
              shift_reg <= LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);
              count     <= count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_piso_serializer_tx.sv
// Bench for piso_serializer_tx: LSB-first, MSB-first and 1-bit instances,
// checked with a vector table, corner sequences and a queue-based model.
module tb_piso_serializer_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  piso_serializer_tx_if #(.WIDTH(8)) if_lsb ();
  piso_serializer_tx_if #(.WIDTH(8)) if_msb ();
  piso_serializer_tx_if #(.WIDTH(1)) if_one ();

  piso_serializer_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (.clk(clk), .reset(reset), .bus(if_lsb));
  piso_serializer_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (.clk(clk), .reset(reset), .bus(if_msb));
  piso_serializer_tx #(.WIDTH(1), .LSB_FIRST(1'b1)) dut_one (.clk(clk), .reset(reset), .bus(if_one));

  typedef struct packed {
    logic load_ready;
    logic ser_out;
    logic ser_valid;
    logic ser_last;
    logic busy;
    logic done;
  } obs_t;

  typedef struct {
    int         sel;
    logic       lv;
    logic [7:0] d;
    logic       sr;
    obs_t       exp;
  } vec_t;

  function automatic obs_t exp_shift(logic b, logic last);
    return {1'b0, b, 1'b1, last, 1'b1, 1'b0};
  endfunction

  function automatic obs_t exp_idle(logic dn);
    return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, dn};
  endfunction

  function automatic obs_t get_obs(int sel);
    obs_t o;
    o = '0;
    case (sel)
      0: o = {if_lsb.load_ready, if_lsb.ser_out, if_lsb.ser_valid, if_lsb.ser_last, if_lsb.busy, if_lsb.done};
      1: o = {if_msb.load_ready, if_msb.ser_out, if_msb.ser_valid, if_msb.ser_last, if_msb.busy, if_msb.done};
      default: o = {if_one.load_ready, if_one.ser_out, if_one.ser_valid, if_one.ser_last, if_one.busy, if_one.done};
    endcase
    return o;
  endfunction

  // Drive one instance's inputs, then let one clock edge pass and settle.
  task automatic applyStimulus(int sel, logic lv, logic [7:0] d, logic sr);
    case (sel)
      0: begin if_lsb.load_valid = lv; if_lsb.load_data = d; if_lsb.ser_ready = sr; end
      1: begin if_msb.load_valid = lv; if_msb.load_data = d; if_msb.ser_ready = sr; end
      default: begin if_one.load_valid = lv; if_one.load_data = d[0]; if_one.ser_ready = sr; end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string name, int sel, obs_t exp);
    obs_t act;
    act = get_obs(sel);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s dut%0d: got rdy/out/val/last/busy/done=%b expected %b",
               name, sel, act, exp);
    end
  endtask

  // Cycle-level reference: the word in flight is just a queue of bits still to send.
  task automatic run_random(int sel, int cycles);
    bit   q[$];
    logic lv, sr, done_e;
    logic [7:0] d;
    int   w;
    bit   lsb;
    w   = (sel == 2) ? 1 : 8;
    lsb = (sel != 1);
    reset = 1'b1;
    applyStimulus(sel, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      lv = ($urandom_range(0, 2) == 0);
      sr = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom);
      applyStimulus(sel, lv, d, sr);
      done_e = 1'b0;
      if (q.size() == 0) begin
        if (lv) for (int i = 0; i < w; i++) q.push_back(lsb ? d[i] : d[w-1-i]);
      end else if (sr) begin
        void'(q.pop_front());
        done_e = (q.size() == 0);
      end
      if (q.size() == 0) checkOutput("random_idle", sel, exp_idle(done_e));
      else               checkOutput("random_shift", sel, exp_shift(q[0], q.size() == 1));
    end
  endtask

  vec_t tbl[20];
  logic [10:0] t3_bits;

  initial begin
    if_lsb.load_valid = 1'b0; if_lsb.load_data = '0; if_lsb.ser_ready = 1'b0;
    if_msb.load_valid = 1'b0; if_msb.load_data = '0; if_msb.ser_ready = 1'b0;
    if_one.load_valid = 1'b0; if_one.load_data = '0; if_one.ser_ready = 1'b0;

    // T1: 8'hC4 LSB first -> 0,0,1,0,0,0,1,1 then done
    tbl[0]  = '{0, 1'b1, 8'hC4, 1'b1, exp_shift(1'b0, 1'b0)};
    tbl[1]  = '{0, 1'b0, 8'h00, 1'b1, exp_shift(1'b0, 1'b0)};
    tbl[2]  = '{0, 1'b0, 8'h00, 1'b1, exp_shift(1'b1, 1'b0)};
    tbl[3]  = '{0, 1'b0, 8'h00, 1'b1, exp_shift(1'b0, 1'b0)};
    tbl[4]  = '{0, 1'b0, 8'h00, 1'b1, exp_shift(1'b0, 1'b0)};
    tbl[5]  = '{0, 1'b0, 8'h00, 1'b1, exp_shift(1'b0, 1'b0)};
    tbl[6]  = '{0, 1'b0, 8'h00, 1'b1, exp_shift(1'b1, 1'b0)};
    tbl[7]  = '{0, 1'b0, 8'h00, 1'b1, exp_shift(1'b1, 1'b1)};
    tbl[8]  = '{0, 1'b0, 8'h00, 1'b1, exp_idle(1'b1)};
    tbl[9]  = '{0, 1'b0, 8'h00, 1'b1, exp_idle(1'b0)};
    // T2: 8'hC4 MSB first -> 1,1,0,0,0,1,0,0 then done
    tbl[10] = '{1, 1'b1, 8'hC4, 1'b1, exp_shift(1'b1, 1'b0)};
    tbl[11] = '{1, 1'b0, 8'h00, 1'b1, exp_shift(1'b1, 1'b0)};
    tbl[12] = '{1, 1'b0, 8'h00, 1'b1, exp_shift(1'b0, 1'b0)};
    tbl[13] = '{1, 1'b0, 8'h00, 1'b1, exp_shift(1'b0, 1'b0)};
    tbl[14] = '{1, 1'b0, 8'h00, 1'b1, exp_shift(1'b0, 1'b0)};
    tbl[15] = '{1, 1'b0, 8'h00, 1'b1, exp_shift(1'b1, 1'b0)};
    tbl[16] = '{1, 1'b0, 8'h00, 1'b1, exp_shift(1'b0, 1'b0)};
    tbl[17] = '{1, 1'b0, 8'h00, 1'b1, exp_shift(1'b0, 1'b1)};
    tbl[18] = '{1, 1'b0, 8'h00, 1'b1, exp_idle(1'b1)};
    tbl[19] = '{1, 1'b0, 8'h00, 1'b1, exp_idle(1'b0)};

    reset = 1'b1;
    applyStimulus(0, 1'b1, 8'hAA, 1'b1);
    applyStimulus(0, 1'b1, 8'hAA, 1'b1);
    for (int s = 0; s < 3; s++) checkOutput("reset_state", s, exp_idle(1'b0));
    reset = 1'b0;
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    checkOutput("idle_after_reset", 0, exp_idle(1'b0));

    for (int i = 0; i < 20; i++) begin
      applyStimulus(tbl[i].sel, tbl[i].lv, tbl[i].d, tbl[i].sr);
      checkOutput($sformatf("table_row%0d", i), tbl[i].sel, tbl[i].exp);
    end

    // T3: stall three edges while bit 2 (a 1) is on the line; cycle c uses t3_bits[c-1]
    t3_bits = 11'b11000111100;
    applyStimulus(0, 1'b1, 8'hC4, 1'b1);
    for (int c = 1; c <= 11; c++) begin
      checkOutput($sformatf("stall_cycle%0d", c), 0, exp_shift(t3_bits[c-1], c == 11));
      applyStimulus(0, 1'b0, 8'h00, (c >= 3 && c <= 5) ? 1'b0 : 1'b1);
    end
    checkOutput("stall_done", 0, exp_idle(1'b1));
    applyStimulus(0, 1'b0, 8'h00, 1'b1);

    // T4: load_valid held with 8'hF0 during SHIFT is ignored until the done cycle
    applyStimulus(0, 1'b1, 8'h0F, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      checkOutput($sformatf("ignore_load_bit%0d", c), 0, exp_shift(c <= 4, c == 8));
      applyStimulus(0, 1'b1, 8'hF0, 1'b1);
    end
    checkOutput("ignore_load_done", 0, exp_idle(1'b1));
    applyStimulus(0, 1'b1, 8'hF0, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      checkOutput($sformatf("second_word_bit%0d", c), 0, exp_shift(c > 4, c == 8));
      applyStimulus(0, 1'b0, 8'h00, 1'b1);
    end
    checkOutput("second_word_done", 0, exp_idle(1'b1));

    // T5: reset after the third bit abandons the frame with no done pulse
    applyStimulus(0, 1'b1, 8'hFF, 1'b1);
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    checkOutput("pre_reset_bit3", 0, exp_shift(1'b1, 1'b0));
    reset = 1'b1;
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    checkOutput("midframe_reset", 0, exp_idle(1'b0));
    reset = 1'b0;
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    checkOutput("no_done_after_reset", 0, exp_idle(1'b0));

    // T6: WIDTH=1 sends a single last beat then done
    applyStimulus(2, 1'b1, 8'h01, 1'b1);
    checkOutput("width1_beat", 2, exp_shift(1'b1, 1'b1));
    applyStimulus(2, 1'b0, 8'h00, 1'b1);
    checkOutput("width1_done", 2, exp_idle(1'b1));
    applyStimulus(2, 1'b0, 8'h00, 1'b1);
    checkOutput("width1_idle", 2, exp_idle(1'b0));

    for (int s = 0; s < 3; s++) run_random(s, 400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
